// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold, shift right/left, parallel load, preset/clear,
// plus an automatic LSB-first serialiser with busy/done status.
module shift_reg_univ #(
  parameter int unsigned            WIDTH      = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL  = '0,
  parameter logic [WIDTH-1:0]       PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      // Serialisation owns the register; start/en/mode are ignored until it ends.
      q_d   = {sin_r, q_q[WIDTH-1:1]};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      q_d    = d;
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH);
    end else if (en) begin
      case (mode)
        2'b01:   q_d = {sin_r, q_q[WIDTH-1:1]};
        2'b10:   q_d = {q_q[WIDTH-2:0], sin_l};
        2'b11:   q_d = d;
        default: q_d = q_q;
      endcase
    end
  end

  // Clear dominates preset; both abort a running serialisation without a done pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (pr) begin
      q_q    <= PRESET_VAL;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
